// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding request, REQ -> WAIT -> HOLD per instruction.
// Build option YSYX_22040237_IFU_MISALIGN_CHK_EN traps misaligned redirect targets.
module ysyx_22040237_ifu (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        inst_fault_o,
  input  logic        pc_jump_flag_i,
  input  logic [63:0] pc_jump_addr_i,
  output logic        inst_misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_inst;
  logic        r_fault;
  logic        r_misalign;

  logic        w_fire;
  logic [63:0] w_pc_inc;
  logic [63:0] w_jump_tgt;
  logic        w_misalign_jump;

  assign w_fire   = (r_state == S_HOLD) & inst_ready_i;
  assign w_pc_inc = r_pc + 64'd4;

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  assign w_jump_tgt      = pc_jump_addr_i;
  assign w_misalign_jump = pc_jump_flag_i & (pc_jump_addr_i[1:0] != 2'b00);
  assign inst_misalign_o = r_misalign;
`else
  // Without the check, low target bits are dropped so the PC stays word aligned.
  assign w_jump_tgt      = pc_jump_addr_i & ~64'd3;
  assign w_misalign_jump = 1'b0;
  assign inst_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_inst     <= 32'd0;
      r_fault    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A trapped misaligned redirect parks the unit here until reset.
          if (!r_misalign) r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_req_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            r_inst  <= imem_rsp_err_i ? INST_NOP : imem_rsp_data_i;
            r_fault <= imem_rsp_err_i;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_fire) begin
            if (w_misalign_jump) begin
              r_misalign <= 1'b1;
              r_pc       <= w_jump_tgt;
              r_state    <= S_IDLE;
            end else begin
              r_pc    <= pc_jump_flag_i ? w_jump_tgt : w_pc_inc;
              r_state <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid_o = (r_state == S_REQ);
  assign imem_req_addr_o  = r_pc;
  assign inst_valid_o     = (r_state == S_HOLD);
  assign inst_o           = r_inst;
  assign pc_o             = r_pc;
  assign inst_fault_o     = (r_state == S_HOLD) & r_fault;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for ysyx_22040237_ifu with a response scoreboard queue.
module tb_ysyx_22040237_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_fault_o;
  logic        pc_jump_flag_i;
  logic [63:0] pc_jump_addr_i;
  logic        inst_misalign_o;

  ysyx_22040237_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .inst_fault_o     (inst_fault_o),
    .pc_jump_flag_i   (pc_jump_flag_i),
    .pc_jump_addr_i   (pc_jump_addr_i),
    .inst_misalign_o  (inst_misalign_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_pc;
  int          t_req;
  int          t_hold;
  int          t_rel;
  int          t_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full fetch: request handshake, response, hold, then fire with optional redirect.
  task automatic fetch_one(input logic [31:0] data, input logic err, input int req_stall,
                           input int rsp_delay, input int dec_stall, input logic jmp,
                           input logic [63:0] jaddr);
    int   n;
    exp_t e;
    imem_req_ready_i = 1'b0;
    n = 0;
    while (!imem_req_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    t_req = cyc;
    check("req_valid", {63'd0, imem_req_valid_o}, 64'd1);
    check("req_addr", imem_req_addr_o, exp_pc);
    check("inst_valid_in_req", {63'd0, inst_valid_o}, 64'd0);
    for (int i = 0; i < req_stall; i++) begin
      pc_jump_flag_i = 1'b1;
      pc_jump_addr_i = 64'h0000_0000_1234_0000;
      imem_rsp_valid_i = 1'b1;
      @(negedge clk);
      check("req_stall_valid", {63'd0, imem_req_valid_o}, 64'd1);
      check("req_stall_addr", imem_req_addr_o, exp_pc);
    end
    pc_jump_flag_i   = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    check("wait_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    for (int i = 0; i < rsp_delay; i++) begin
      imem_req_ready_i = 1'b1;
      @(negedge clk);
      check("wait_inst_valid", {63'd0, inst_valid_o}, 64'd0);
      check("wait_no_req", {63'd0, imem_req_valid_o}, 64'd0);
    end
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    imem_rsp_err_i   = err;
    sb.push_back('{pc: exp_pc, inst: (err ? 32'h0000_0013 : data), fault: err});
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    imem_rsp_data_i  = $urandom;
    t_hold = cyc;
    check("hold_valid", {63'd0, inst_valid_o}, 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("hold_inst", {32'd0, inst_o}, {32'd0, e.inst});
      check("hold_pc", pc_o, e.pc);
      check("hold_fault", {63'd0, inst_fault_o}, {63'd0, e.fault});
      for (int i = 0; i < dec_stall; i++) begin
        pc_jump_flag_i   = 1'b1;
        pc_jump_addr_i   = 64'h0000_0000_5678_0000;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        imem_req_ready_i = 1'b1;
        @(negedge clk);
        check("stall_valid", {63'd0, inst_valid_o}, 64'd1);
        check("stall_inst", {32'd0, inst_o}, {32'd0, e.inst});
        check("stall_pc", pc_o, e.pc);
        check("stall_no_req", {63'd0, imem_req_valid_o}, 64'd0);
      end
    end
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    inst_ready_i     = 1'b1;
    pc_jump_flag_i   = jmp;
    pc_jump_addr_i   = jaddr;
    @(negedge clk);
    inst_ready_i   = 1'b0;
    pc_jump_flag_i = 1'b0;
    pc_jump_addr_i = 64'h0000_0000_0BAD_0000;
    check("after_fire_valid", {63'd0, inst_valid_o}, 64'd0);
    if (jmp) begin
      exp_pc = jaddr;
`ifndef YSYX_22040237_IFU_MISALIGN_CHK_EN
      exp_pc[1:0] = 2'b00;
`endif
    end else begin
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  initial begin
    rst              = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    imem_rsp_err_i   = 1'b0;
    inst_ready_i     = 1'b0;
    pc_jump_flag_i   = 1'b0;
    pc_jump_addr_i   = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    check("rst_fault", {63'd0, inst_fault_o}, 64'd0);
    check("rst_misalign", {63'd0, inst_misalign_o}, 64'd0);
    check("rst_pc", pc_o, 64'h0000_0000_8000_0000);

    rst    = 1'b0;
    t_rel  = cyc;
    exp_pc = 64'h0000_0000_8000_0000;

    fetch_one(32'h0000_0093, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    check("first_req_latency", 64'(t_req - t_rel), 64'd1);
    check("first_inst_latency", 64'(t_hold - t_rel), 64'd3);
    t_prev = t_req;
    fetch_one(32'h0010_0113, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    check("seq_spacing_1", 64'(t_req - t_prev), 64'd3);
    t_prev = t_req;
    fetch_one(32'h0020_0193, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    check("seq_spacing_2", 64'(t_req - t_prev), 64'd3);

    // Backpressure on both sides with redirect noise while not firing.
    fetch_one(32'h0030_0213, 1'b0, 4, 1, 5, 1'b0, 64'd0);
    // Faulted fetch at 0x80000010, then a clean one at 0x80000014 that redirects.
    fetch_one(32'hABCD_1234, 1'b1, 0, 0, 0, 1'b0, 64'd0);
    fetch_one(32'h0050_0293, 1'b0, 0, 2, 1, 1'b1, 64'h0000_0000_8000_0100);
    // Sequential advance wraps at the top of the address space.
    fetch_one(32'h0060_0313, 1'b0, 0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(32'h0070_0393, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    check("wrap_pc", exp_pc, 64'd0);

    // Reset while waiting for a response.
    imem_req_ready_i = 1'b0;
    for (int n = 0; n < 10 && !imem_req_valid_o; n++) @(negedge clk);
    check("wrap_req_addr", imem_req_addr_o, 64'd0);
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    check("mid_rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    check("mid_rst_pc", pc_o, 64'h0000_0000_8000_0000);
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 64'h0000_0000_8000_0000;
    fetch_one(32'h0080_0413, 1'b0, 0, 0, 0, 1'b1, 64'h0000_0000_8000_0102);

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    check("misalign_flag", {63'd0, inst_misalign_o}, 64'd1);
    check("misalign_pc", pc_o, 64'h0000_0000_8000_0102);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("misalign_no_req", {63'd0, imem_req_valid_o}, 64'd0);
    end
`else
    check("misalign_tied_low", {63'd0, inst_misalign_o}, 64'd0);
    fetch_one(32'h0090_0493, 1'b0, 0, 0, 0, 1'b0, 64'd0);
    check("aligned_redirect_pc", exp_pc, 64'h0000_0000_8000_0104);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
